// File: rtl/ball_motion_engine_pkg.sv
// Shared types and constants for the per-ball motion engine.
// Hit-edge bit order follows the collision detector: {left, top, right, bottom}.
package ball_motion_engine_pkg;

    localparam int DEF_FRAC_BITS = 6;
    localparam int DEF_SPEED_W   = 12;
    localparam int POS_INT_W     = 11;

    typedef logic [1:0] motion_state_t;

    localparam motion_state_t ST_STILL    = 2'd0;
    localparam motion_state_t ST_CHARGE   = 2'd1;
    localparam motion_state_t ST_ROLL     = 2'd2;
    localparam motion_state_t ST_POCKETED = 2'd3;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    // One charge update on a single axis; opposite pulses cancel, magnitude clamps at max_shot.
    function automatic int charge_step(int shot, logic inc, logic dec, int step, int max_shot);
        int r;
        r = shot;
        if (inc && !dec && (shot < max_shot))
            r = (shot + step > max_shot) ? max_shot : shot + step;
        else if (dec && !inc && (-shot < max_shot))
            r = (shot - step < -max_shot) ? -max_shot : shot - step;
        return r;
    endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// Event inputs and position/velocity outputs of one ball.
// master = stimulus side (game logic), slave = the motion engine.
interface ball_motion_engine_if #(
    parameter int SPEED_W = 12
);
    logic                       startOfFrame;
    logic                       chargeUp;
    logic                       chargeDown;
    logic                       chargeLeft;
    logic                       chargeRight;
    logic                       releaseBall;
    logic                       collBall;
    logic [3:0]                 hitEdge;
    logic                       collWall;
    logic [1:0]                 wallAxis;
    logic                       collHole;
    logic                       respawn;
    logic signed [ball_motion_engine_pkg::POS_INT_W-1:0] topLeftX;
    logic signed [ball_motion_engine_pkg::POS_INT_W-1:0] topLeftY;
    logic signed [SPEED_W-1:0]  XspeedOUT;
    logic signed [SPEED_W-1:0]  YspeedOUT;
    logic signed [SPEED_W-1:0]  shotX;
    logic signed [SPEED_W-1:0]  shotY;
    logic                       moving;
    logic                       pocketed;

    modport master (
        output startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
               collBall, hitEdge, collWall, wallAxis, collHole, respawn,
        input  topLeftX, topLeftY, XspeedOUT, YspeedOUT, shotX, shotY, moving, pocketed
    );

    modport slave (
        input  startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
               collBall, hitEdge, collWall, wallAxis, collHole, respawn,
        output topLeftX, topLeftY, XspeedOUT, YspeedOUT, shotX, shotY, moving, pocketed
    );
endinterface

// File: rtl/ball_motion_engine_axis.sv
// One axis of ball motion: fixed-point position, signed velocity, friction,
// reflect/kick with a once-per-frame debounce flag.
module axis_integrator
    import ball_motion_engine_pkg::*;
#(
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int SPEED_W    = DEF_SPEED_W,
    parameter int INIT_POS   = 400,
    parameter int PARK_POS   = 600,
    parameter int FRICTION   = 1,
    parameter int MIN_SPEED  = 2,
    parameter int KICK_SPEED = 100,
    parameter int WALL_BOOST = 5
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       frame_i,
    input  logic                       flag_clr_i,
    input  logic                       ball_i,
    input  logic                       edge_p_i,
    input  logic                       edge_n_i,
    input  logic                       wall_i,
    input  logic                       load_i,
    input  logic signed [SPEED_W-1:0]  load_val_i,
    input  logic                       park_i,
    input  logic                       init_i,
    output logic signed [POS_INT_W-1:0] pos_o,
    output logic signed [SPEED_W-1:0]  vel_o,
    output logic signed [SPEED_W-1:0]  vel_d_o
);
    localparam int POS_W = POS_INT_W + FRAC_BITS;
    localparam int WW    = SPEED_W + 2;

    localparam logic signed [WW-1:0]    VMAX    = WW'((1 << (SPEED_W - 1)) - 1);
    localparam logic signed [WW-1:0]    VMIN    = -VMAX;
    localparam logic signed [WW-1:0]    KICK_W  = WW'(KICK_SPEED);
    localparam logic signed [WW-1:0]    BOOST_W = WW'(WALL_BOOST);
    localparam logic signed [WW-1:0]    FRIC_W  = WW'(FRICTION);
    localparam logic signed [WW-1:0]    MIN_W   = WW'(MIN_SPEED);
    localparam logic signed [SPEED_W-1:0] FRIC_S = SPEED_W'(FRICTION);
    localparam logic signed [POS_W-1:0] INIT_FP = POS_W'(INIT_POS * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] PARK_FP = POS_W'(PARK_POS * (2 ** FRAC_BITS));

    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic signed [SPEED_W-1:0] vel_q, vel_d;
    logic                      flag_q, flag_d;

    logic signed [WW-1:0]      v_w, abs_w;
    logic signed [SPEED_W-1:0] col_v;
    logic                      hit_ok, touched, v_neg, v_zero, v_pos;

    function automatic logic signed [SPEED_W-1:0] sat(input logic signed [WW-1:0] v);
        if (v > VMAX)
            return SPEED_W'(VMAX);
        else if (v < VMIN)
            return SPEED_W'(VMIN);
        else
            return SPEED_W'(v);
    endfunction

    always_comb begin
        v_neg   = vel_q[SPEED_W-1];
        v_zero  = (vel_q == '0);
        v_pos   = !v_neg && !v_zero;
        // A collision landing on the frame pulse belongs to the new frame.
        hit_ok  = !flag_q || flag_clr_i;
        touched = 1'b0;
        v_w     = WW'(vel_q);

        if (park_i || init_i) begin
            v_w = '0;
        end else if (load_i) begin
            v_w = WW'(load_val_i);
        end else if (ball_i && hit_ok) begin
            if (v_zero) begin
                if (edge_p_i) begin
                    v_w     = KICK_W;
                    touched = 1'b1;
                end else if (edge_n_i) begin
                    v_w     = -KICK_W;
                    touched = 1'b1;
                end
            end else if ((edge_p_i && v_neg) || (edge_n_i && v_pos)) begin
                v_w     = -v_w;
                touched = 1'b1;
            end
        end else if (wall_i && hit_ok && !v_zero) begin
            v_w     = v_neg ? (-v_w + BOOST_W) : (-v_w - BOOST_W);
            touched = 1'b1;
        end

        col_v = sat(v_w);
        abs_w = col_v[SPEED_W-1] ? -WW'(col_v) : WW'(col_v);
        vel_d = col_v;
        if (frame_i) begin
            if ((abs_w <= MIN_W) || (abs_w <= FRIC_W))
                vel_d = '0;
            else
                vel_d = col_v[SPEED_W-1] ? (col_v + FRIC_S) : (col_v - FRIC_S);
        end

        // Position always integrates the velocity held at the start of the cycle.
        pos_d = pos_q;
        if (park_i)
            pos_d = PARK_FP;
        else if (init_i)
            pos_d = INIT_FP;
        else if (frame_i)
            pos_d = pos_q + POS_W'(vel_q);

        flag_d = flag_q;
        if (park_i || init_i)
            flag_d = 1'b0;
        else if (touched)
            flag_d = 1'b1;
        else if (flag_clr_i)
            flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_q  <= INIT_FP;
            vel_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            vel_q  <= vel_d;
            flag_q <= flag_d;
        end
    end

    assign pos_o   = pos_q[POS_W-1:FRAC_BITS];
    assign vel_o   = vel_q;
    assign vel_d_o = vel_d;

endmodule

// File: rtl/ball_motion_engine.sv
// Per-ball motion engine: motion FSM and cue-shot charge registers around two axis integrators.
//   state       | meaning
//   ST_STILL    | at rest, waiting for a cue charge or a hit from another ball
//   ST_CHARGE   | cue shot being charged, ball still at rest
//   ST_ROLL     | moving; integrated and slowed once per frame
//   ST_POCKETED | parked off-table until respawn
module ball_motion_engine
    import ball_motion_engine_pkg::*;
#(
    parameter int IS_CUE     = 0,
    parameter int INIT_X     = 400,
    parameter int INIT_Y     = 220,
    parameter int PARK_X     = 600,
    parameter int PARK_Y     = 460,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int SPEED_W    = DEF_SPEED_W,
    parameter int MAX_SHOT   = 800,
    parameter int SHOT_STEP  = 100,
    parameter int FRICTION   = 1,
    parameter int MIN_SPEED  = 2,
    parameter int KICK_SPEED = 100,
    parameter int WALL_BOOST = 5
) (
    input  logic                 clk,
    input  logic                 resetN,
    ball_motion_engine_if.slave  bus
);
    localparam bit CUE = (IS_CUE != 0);

    motion_state_t             state_q, state_d;
    logic signed [SPEED_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
    logic signed [SPEED_W-1:0] shot_x_nx, shot_y_nx;
    logic signed [SPEED_W-1:0] vx, vy, vx_d, vy_d;
    logic signed [POS_INT_W-1:0] px, py;
    logic live, hole, ball, wall, any_charge, load, frame, init;

    always_comb begin
        live       = (state_q != ST_POCKETED);
        hole       = live && bus.collHole;
        ball       = live && !bus.collHole && bus.collBall;
        wall       = live && !bus.collHole && !bus.collBall && bus.collWall;
        any_charge = CUE && (bus.chargeUp || bus.chargeDown || bus.chargeLeft || bus.chargeRight);
        load       = CUE && (state_q == ST_CHARGE) && !bus.collHole && !bus.collBall
                     && !bus.collWall && bus.releaseBall;
        frame      = bus.startOfFrame && (state_q == ST_ROLL) && !bus.collHole;
        init       = bus.respawn && (state_q == ST_POCKETED);

        shot_x_nx = SPEED_W'(charge_step(int'(shot_x_q), bus.chargeLeft, bus.chargeRight,
                                         SHOT_STEP, MAX_SHOT));
        shot_y_nx = SPEED_W'(charge_step(int'(shot_y_q), bus.chargeUp, bus.chargeDown,
                                         SHOT_STEP, MAX_SHOT));

        state_d  = state_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;

        if (hole) begin
            state_d  = ST_POCKETED;
            shot_x_d = '0;
            shot_y_d = '0;
        end else begin
            case (state_q)
                ST_STILL: begin
                    if (ball) begin
                        state_d = ST_ROLL;
                    end else if (!bus.collWall && any_charge) begin
                        state_d  = ST_CHARGE;
                        shot_x_d = shot_x_nx;
                        shot_y_d = shot_y_nx;
                    end
                end
                ST_CHARGE: begin
                    if (ball) begin
                        state_d  = ST_ROLL;
                        shot_x_d = '0;
                        shot_y_d = '0;
                    end else if (load) begin
                        shot_x_d = '0;
                        shot_y_d = '0;
                        state_d  = ((shot_x_q != '0) || (shot_y_q != '0)) ? ST_ROLL : ST_STILL;
                    end else if (!bus.collWall && any_charge) begin
                        shot_x_d = shot_x_nx;
                        shot_y_d = shot_y_nx;
                    end
                end
                ST_ROLL: begin
                    if (bus.startOfFrame && (vx_d == '0) && (vy_d == '0))
                        state_d = ST_STILL;
                end
                ST_POCKETED: begin
                    if (bus.respawn)
                        state_d = ST_STILL;
                end
                default: state_d = ST_STILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_STILL;
            shot_x_q <= '0;
            shot_y_q <= '0;
        end else begin
            state_q  <= state_d;
            shot_x_q <= shot_x_d;
            shot_y_q <= shot_y_d;
        end
    end

    // X kicks positive when struck on the left edge; Y positive when struck on the top edge.
    axis_integrator #(
        .FRAC_BITS(FRAC_BITS), .SPEED_W(SPEED_W), .INIT_POS(INIT_X), .PARK_POS(PARK_X),
        .FRICTION(FRICTION), .MIN_SPEED(MIN_SPEED), .KICK_SPEED(KICK_SPEED),
        .WALL_BOOST(WALL_BOOST)
    ) u_axis_x (
        .clk(clk), .resetN(resetN),
        .frame_i(frame), .flag_clr_i(bus.startOfFrame),
        .ball_i(ball), .edge_p_i(bus.hitEdge[EDGE_LEFT]), .edge_n_i(bus.hitEdge[EDGE_RIGHT]),
        .wall_i(wall && bus.wallAxis[0]),
        .load_i(load), .load_val_i(shot_x_q),
        .park_i(hole), .init_i(init),
        .pos_o(px), .vel_o(vx), .vel_d_o(vx_d)
    );

    axis_integrator #(
        .FRAC_BITS(FRAC_BITS), .SPEED_W(SPEED_W), .INIT_POS(INIT_Y), .PARK_POS(PARK_Y),
        .FRICTION(FRICTION), .MIN_SPEED(MIN_SPEED), .KICK_SPEED(KICK_SPEED),
        .WALL_BOOST(WALL_BOOST)
    ) u_axis_y (
        .clk(clk), .resetN(resetN),
        .frame_i(frame), .flag_clr_i(bus.startOfFrame),
        .ball_i(ball), .edge_p_i(bus.hitEdge[EDGE_TOP]), .edge_n_i(bus.hitEdge[EDGE_BOTTOM]),
        .wall_i(wall && bus.wallAxis[1]),
        .load_i(load), .load_val_i(shot_y_q),
        .park_i(hole), .init_i(init),
        .pos_o(py), .vel_o(vy), .vel_d_o(vy_d)
    );

    assign bus.topLeftX  = px;
    assign bus.topLeftY  = py;
    assign bus.XspeedOUT = vx;
    assign bus.YspeedOUT = vy;
    assign bus.shotX     = shot_x_q;
    assign bus.shotY     = shot_y_q;
    assign bus.moving    = (state_q == ST_ROLL);
    assign bus.pocketed  = (state_q == ST_POCKETED);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Scoreboard bench for ball_motion_engine (cue ball configuration, default geometry).
module tb_ball_motion_engine;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    ball_motion_engine_if #(.SPEED_W(12)) bus ();

    ball_motion_engine #(.IS_CUE(1)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    typedef struct {
        string name;
        int    x, y, vx, vy, sx, sy;
        bit    mv, pk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic clr();
        bus.startOfFrame = 1'b0;
        bus.chargeUp     = 1'b0;
        bus.chargeDown   = 1'b0;
        bus.chargeLeft   = 1'b0;
        bus.chargeRight  = 1'b0;
        bus.releaseBall  = 1'b0;
        bus.collBall     = 1'b0;
        bus.hitEdge      = 4'b0000;
        bus.collWall     = 1'b0;
        bus.wallAxis     = 2'b00;
        bus.collHole     = 1'b0;
        bus.respawn      = 1'b0;
    endtask

    // Inputs set before calling are sampled on the next rising edge, then released.
    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            step();
        end
    endtask

    task automatic hole_respawn();
        bus.collHole = 1'b1;
        step();
        bus.respawn = 1'b1;
        step();
    endtask

    task automatic exp_state(input string n, input int x, input int y, input int vx, input int vy,
                             input int sx, input int sy, input bit mv, input bit pk);
        exp_t e;
        e.name = n; e.x = x; e.y = y; e.vx = vx; e.vy = vy;
        e.sx = sx; e.sy = sy; e.mv = mv; e.pk = pk;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (int'(bus.topLeftX) != mon_e.x || int'(bus.topLeftY) != mon_e.y ||
                int'(bus.XspeedOUT) != mon_e.vx || int'(bus.YspeedOUT) != mon_e.vy ||
                int'(bus.shotX) != mon_e.sx || int'(bus.shotY) != mon_e.sy ||
                bus.moving != mon_e.mv || bus.pocketed != mon_e.pk) begin
                errors++;
                $display("FAIL %s: got x=%0d y=%0d vx=%0d vy=%0d sx=%0d sy=%0d mv=%0b pk=%0b | want x=%0d y=%0d vx=%0d vy=%0d sx=%0d sy=%0d mv=%0b pk=%0b",
                         mon_e.name, int'(bus.topLeftX), int'(bus.topLeftY),
                         int'(bus.XspeedOUT), int'(bus.YspeedOUT), int'(bus.shotX),
                         int'(bus.shotY), bus.moving, bus.pocketed,
                         mon_e.x, mon_e.y, mon_e.vx, mon_e.vy, mon_e.sx, mon_e.sy,
                         mon_e.mv, mon_e.pk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        exp_state("reset", 400, 220, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Cue shot: Y=300 (1/64 px), X=200; one frame moves 300/64 -> +4, 200/64 -> +3
        repeat (3) begin bus.chargeUp = 1'b1; step(); end
        repeat (2) begin bus.chargeLeft = 1'b1; step(); end
        exp_state("charge", 400, 220, 0, 0, 200, 300, 0, 0);
        bus.releaseBall = 1'b1; step();
        exp_state("release", 400, 220, 200, 300, 0, 0, 1, 0);
        frames(1);
        exp_state("frame1", 403, 224, 199, 299, 0, 0, 1, 0);
        bus.collHole = 1'b1; step();
        exp_state("hole_roll", 600, 460, 0, 0, 0, 0, 0, 1);
        bus.collBall = 1'b1; bus.hitEdge = 4'b0100; bus.chargeUp = 1'b1; bus.startOfFrame = 1'b1;
        step();
        exp_state("pocket_ignore", 600, 460, 0, 0, 0, 0, 0, 1);
        bus.respawn = 1'b1; step();
        exp_state("respawn", 400, 220, 0, 0, 0, 0, 0, 0);

        // Charge saturation, then release together with frame: no integration that cycle
        repeat (9) begin bus.chargeDown = 1'b1; step(); end
        exp_state("sat_down", 400, 220, 0, 0, 0, -800, 0, 0);
        bus.releaseBall = 1'b1; bus.startOfFrame = 1'b1; step();
        exp_state("release_frame", 400, 220, 0, -800, 0, 0, 1, 0);
        hole_respawn();

        // Left-edge kick X=+100, 50 frames -> X=50, pos 25600+sum(100..51)=29375 -> 458
        bus.collBall = 1'b1; bus.hitEdge = 4'b1000; step();
        exp_state("kick_x", 400, 220, 100, 0, 0, 0, 1, 0);
        frames(50);
        exp_state("decay50", 458, 220, 50, 0, 0, 0, 1, 0);
        bus.collWall = 1'b1; bus.wallAxis = 2'b01; step();
        exp_state("wall", 458, 220, -55, 0, 0, 0, 1, 0);
        bus.collWall = 1'b1; bus.wallAxis = 2'b01; step();
        exp_state("wall_debounce", 458, 220, -55, 0, 0, 0, 1, 0);
        frames(1);
        exp_state("wall_frame", 458, 220, -54, 0, 0, 0, 1, 0);
        bus.collWall = 1'b1; bus.wallAxis = 2'b01; step();
        exp_state("wall_again", 458, 220, 59, 0, 0, 0, 1, 0);
        bus.collBall = 1'b1; bus.hitEdge = 4'b0010; step();
        exp_state("ball_debounced", 458, 220, 59, 0, 0, 0, 1, 0);
        frames(1);
        exp_state("ball_frame", 459, 220, 58, 0, 0, 0, 1, 0);
        bus.collBall = 1'b1; bus.hitEdge = 4'b0010; step();
        exp_state("ball_reflect", 459, 220, -58, 0, 0, 0, 1, 0);
        hole_respawn();

        // Top-edge kick Y=+100; after 98 frames Y=2, pos 14080+5047 -> 298; next frame stops
        bus.collBall = 1'b1; bus.hitEdge = 4'b0100; step();
        exp_state("kick_y", 400, 220, 0, 100, 0, 0, 1, 0);
        frames(98);
        exp_state("decay98", 400, 298, 0, 2, 0, 0, 1, 0);
        frames(1);
        exp_state("stop", 400, 298, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a charge
        repeat (3) begin bus.chargeLeft = 1'b1; step(); end
        exp_state("charge_x", 400, 298, 0, 0, 300, 0, 0, 0);
        @(posedge clk);
        #1 resetN = 1'b0;
        exp_state("reset_mid", 400, 220, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        bus.chargeUp = 1'b1; step();
        exp_state("recharge", 400, 220, 0, 0, 0, 100, 0, 0);
        step();

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
